mux_8_to_1: RTL and testbench

Eight-input, one-output selector with a registered output stage. One of eight equal-width input lanes, packed into bus `I`, is chosen by the 3-bit `Sel` and driven onto `Y`. It is a leaf datapath block for lane selection. Its output is registered by default so that it can sit directly in a clocked pipeline, and a parameter provides a purely combinational build.

---
 rtl/mux_8_to_1.sv | 41 ++++
 tb/tb_mux_8_to_1.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_8_to_1.sv
// Eight-lane selector. Lane Sel of the packed bus I appears on Y, either through an
// enabled output register (REG_OUT=1) or directly (REG_OUT=0).
module mux_8_to_1 #(
  parameter int DATA_W  = 1,
  parameter int REG_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*DATA_W-1:0]   I,
  input  logic [2:0]            Sel,
  input  logic                  en,
  output logic [DATA_W-1:0]     Y,
  output logic                  Y_valid
);

  logic [DATA_W-1:0] sel_data;

  // An unknown Sel yields an unknown lane in simulation; no masking on purpose
  assign sel_data = I[{29'd0, Sel} * DATA_W +: DATA_W];

  generate
    if (REG_OUT != 0) begin : g_reg
      // Y holds across disabled cycles, while Y_valid flags only fresh captures
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          Y       <= '0;
          Y_valid <= 1'b0;
        end else begin
          if (en) begin
            Y <= sel_data;
          end
          Y_valid <= en;
        end
      end
    end else begin : g_comb
      assign Y       = rst_n ? sel_data : '0;
      assign Y_valid = rst_n & en;
    end
  endgenerate

endmodule

// File: tb/tb_mux_8_to_1.sv
// Bench for mux_8_to_1: registered 1-bit and 8-bit builds plus a combinational 8-bit
// build, compared against a lane-extraction reference model.
module tb_mux_8_to_1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  Sel;
  logic [7:0]  inNarrow;
  logic [63:0] inWide;
  logic [0:0]  yNarrow;
  logic [7:0]  yWide;
  logic [7:0]  yComb;
  logic        vNarrow;
  logic        vWide;
  logic        vComb;

  int checks = 0;
  int errors = 0;

  // Reference model state for the registered builds
  logic [63:0] expNarrowY = '0;
  logic        expNarrowV = 1'b0;
  logic [63:0] expWideY   = '0;
  logic        expWideV   = 1'b0;

  mux_8_to_1 #(.DATA_W(1), .REG_OUT(1)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .I(inNarrow), .Sel(Sel), .en(en),
    .Y(yNarrow), .Y_valid(vNarrow)
  );

  mux_8_to_1 #(.DATA_W(8), .REG_OUT(1)) dutWide (
    .clk(clk), .rst_n(rst_n), .I(inWide), .Sel(Sel), .en(en),
    .Y(yWide), .Y_valid(vWide)
  );

  mux_8_to_1 #(.DATA_W(8), .REG_OUT(0)) dutComb (
    .clk(clk), .rst_n(rst_n), .I(inWide), .Sel(Sel), .en(en),
    .Y(yComb), .Y_valid(vComb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] laneOf(input logic [63:0] bus, input int sel, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return (bus >> (sel * w)) & mask;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkRegistered(input string tag);
    checkOutput({tag, "_y1"}, {63'd0, yNarrow}, expNarrowY);
    checkOutput({tag, "_v1"}, {63'd0, vNarrow}, {63'd0, expNarrowV});
    checkOutput({tag, "_y8"}, {56'd0, yWide},   expWideY);
    checkOutput({tag, "_v8"}, {63'd0, vWide},   {63'd0, expWideV});
  endtask

  // Drive one input set mid-cycle, check the combinational build, clock it in,
  // check the registered builds, then disturb the inputs and confirm nothing moves
  task automatic applyStimulus(input logic [7:0] i1, input logic [63:0] i8,
                               input int sel, input logic e, input string tag);
    @(negedge clk);
    inNarrow = i1;
    inWide   = i8;
    Sel      = 3'(sel);
    en       = e;
    #1;
    checkOutput({tag, "_comb_y"}, {56'd0, yComb}, laneOf(i8, sel, 8));
    checkOutput({tag, "_comb_v"}, {63'd0, vComb}, {63'd0, e});
    @(posedge clk);
    if (e) begin
      expNarrowY = laneOf({56'd0, i1}, sel, 1);
      expWideY   = laneOf(i8, sel, 8);
    end
    expNarrowV = e;
    expWideV   = e;
    #1;
    checkRegistered(tag);
    inNarrow = ~i1;
    inWide   = ~i8;
    Sel      = ~3'(sel);
    #1;
    checkRegistered({tag, "_between"});
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    Sel      = '0;
    inNarrow = '0;
    inWide   = '0;
    #1;
    checkRegistered("reset");
    checkOutput("reset_comb_y", {56'd0, yComb}, 64'd0);
    checkOutput("reset_comb_v", {63'd0, vComb}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'(1 << k), {$urandom, $urandom}, k, 1'b1, "walk");
      checkOutput("walk_one", {63'd0, yNarrow}, 64'd1);
    end

    applyStimulus(8'hFE, 64'h0, 0, 1'b1, "iso_sel0");
    checkOutput("iso_sel0_zero", {63'd0, yNarrow}, 64'd0);
    applyStimulus(8'h7F, 64'h0, 7, 1'b1, "iso_sel7");
    checkOutput("iso_sel7_zero", {63'd0, yNarrow}, 64'd0);
    for (int s = 1; s < 7; s++) begin
      applyStimulus(8'hFE, 64'h0, s, 1'b1, "iso_mid");
      checkOutput("iso_mid_one", {63'd0, yNarrow}, 64'd1);
    end

    applyStimulus(8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b1, "hold_load");
    for (int n = 0; n < 3; n++) begin
      applyStimulus(8'h00, 64'h0, 3, 1'b0, "hold");
    end
    checkOutput("hold_y_kept", {63'd0, yNarrow}, 64'd1);
    checkOutput("hold_v_low", {63'd0, vNarrow}, 64'd0);
    applyStimulus(8'h00, 64'h0, 3, 1'b1, "hold_release");
    checkOutput("hold_release_y", {63'd0, yNarrow}, 64'd0);

    for (int s = 0; s < 8; s++) begin
      applyStimulus(8'h55, 64'h7766554433221100, s, 1'b1, "wide");
      checkOutput("wide_lane", {56'd0, yWide}, 64'(8'h11 * s));
    end
    for (int s = 0; s < 8; s++) begin
      applyStimulus(8'hAA, 64'h7766554433221100, s, 1'b0, "wide_noen");
    end

    applyStimulus(8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 2, 1'b1, "pre_reset");
    rst_n = 1'b0;
    expNarrowY = '0; expNarrowV = 1'b0;
    expWideY   = '0; expWideV   = 1'b0;
    #1;
    checkRegistered("async_reset");
    checkOutput("async_reset_comb_y", {56'd0, yComb}, 64'd0);
    checkOutput("async_reset_comb_v", {63'd0, vComb}, 64'd0);
    @(posedge clk);
    #1;
    checkRegistered("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h10, 64'h0123_4567_89AB_CDEF, 4, 1'b1, "post_reset");

    for (int n = 0; n < 300; n++) begin
      applyStimulus(8'($urandom), {$urandom, $urandom}, int'($urandom_range(7, 0)),
                    1'($urandom_range(1, 0)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
